pong_game_core: RTL and testbench

Two-player, fully parametrised successor to the single-player animated pong datapath. It sits between the VGA sync generator and the RGB output pins. Ball position, two paddle positions and per-player scores are updated once per frame. A game-control FSM handles serve, scoring pause, win detection and restart. The pixel mux is combinational, from `pixl_x`/`pixl_y`.

---
 rtl/pong_game_core.sv | 238 +++++++++++++++++++++++
 tb/tb_pong_game_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_core.sv
// Two-player pong datapath: paddles, ball, scores and game-control FSM updated once per frame.
// Optional build macro PONG_SPEEDUP_EN makes each paddle hit speed the ball up to BALL_VMAX.
module pong_game_core #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PAD_H        = 72,
  parameter int PAD_W        = 4,
  parameter int LPAD_X       = 32,
  parameter int RPAD_X       = 600,
  parameter int PAD_VEL      = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_V0      = 1,
  parameter int BALL_VMAX    = 6,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         btn_l,
  input  logic [1:0]         btn_r,
  input  logic               start,
  input  logic               video_on,
  input  logic [9:0]         pixl_x,
  input  logic [9:0]         pixl_y,
  output logic [11:0]        RGB,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over
);

  localparam int PAUSE_W = (PAUSE_FRAMES < 2) ? 1 : $clog2(PAUSE_FRAMES + 1);

  localparam logic [9:0]  PAD_INIT  = 10'((V_RES - PAD_H) / 2);
  localparam logic [9:0]  PAD_MAX   = 10'(V_RES - PAD_H);
  localparam logic [9:0]  PAD_STEP  = 10'(PAD_VEL);
  localparam logic [9:0]  BALL_CX   = 10'(H_RES / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  BALL_CY   = 10'(V_RES / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  BALL_YMAX = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0]  RHIT_X    = 10'(RPAD_X - BALL_SIZE);
  localparam logic [9:0]  LHIT_X    = 10'(LPAD_X + PAD_W);
  localparam logic [9:0]  TICK_Y    = 10'(V_RES + 1);
  localparam logic [9:0]  CENTRE_X  = 10'(H_RES / 2);
  localparam logic [9:0]  SPEED_V0  = 10'(BALL_V0);
  localparam logic [10:0] K_HRES    = 11'(H_RES);
  localparam logic [10:0] K_PADH    = 11'(PAD_H);
  localparam logic [10:0] K_PADW    = 11'(PAD_W);
  localparam logic [10:0] K_LPADX   = 11'(LPAD_X);
  localparam logic [10:0] K_RPADX   = 11'(RPAD_X);
  localparam logic [10:0] K_LPADR   = 11'(LPAD_X + PAD_W);
  localparam logic [10:0] K_BALL    = 11'(BALL_SIZE);
  localparam logic [10:0] K_BALLYMX = 11'(V_RES - BALL_SIZE);
  localparam logic [SCORE_W-1:0] K_WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  state_t               r_state;
  logic                 r_startQ, r_startPrev;
  logic [9:0]           r_padL, r_padR, r_ballX, r_ballY;
  logic                 r_dirRight, r_dirDown, r_serveRight;
  logic [SCORE_W-1:0]   r_scoreL, r_scoreR;
  logic                 r_gameOver;
  logic [PAUSE_W-1:0]   r_pause;

  logic                 w_tick, w_startRise;
  logic [9:0]           w_speed;
  logic [10:0]          w_spd11, w_rightEdge;
  logic [9:0]           w_nextX, w_nextY;
  logic                 w_nextDown;
  logic                 w_overlapL, w_overlapR, w_hitL, w_hitR, w_missL, w_missR;
  logic [10:0]          w_px, w_py;
  logic                 w_onLPad, w_onRPad, w_onBall, w_onLine;

`ifdef PONG_SPEEDUP_EN
  logic [9:0] r_speed;
  assign w_speed = r_speed;
`else
  assign w_speed = SPEED_V0;
`endif

  assign w_tick      = (pixl_x == 10'd0) && (pixl_y == TICK_Y);
  assign w_startRise = r_startQ & ~r_startPrev;

  // Paddle step toward a clamped edge; opposing buttons cancel out.
  function automatic logic [9:0] padNext(input logic [9:0] top, input logic [1:0] btn);
    logic [9:0] res;
    res = top;
    if (btn == 2'b10)
      res = ((PAD_MAX - top) < PAD_STEP) ? PAD_MAX : top + PAD_STEP;
    else if (btn == 2'b01)
      res = (top < PAD_STEP) ? 10'd0 : top - PAD_STEP;
    return res;
  endfunction

  always_comb begin
    w_nextY    = r_ballY;
    w_nextDown = r_dirDown;
    if (r_dirDown) begin
      if ({1'b0, r_ballY} + {1'b0, w_speed} > K_BALLYMX) begin
        w_nextY    = BALL_YMAX;
        w_nextDown = 1'b0;
      end else begin
        w_nextY = r_ballY + w_speed;
      end
    end else if (r_ballY < w_speed) begin
      w_nextY    = 10'd0;
      w_nextDown = 1'b1;
    end else begin
      w_nextY = r_ballY - w_speed;
    end
  end

  // Paddle contact is judged against the ball's post-bounce row so both axes resolve in one tick.
  assign w_spd11     = {1'b0, w_speed};
  assign w_rightEdge = {1'b0, r_ballX} + K_BALL;
  assign w_overlapR  = ({1'b0, w_nextY} <= {1'b0, r_padR} + K_PADH - 11'd1) &&
                       ({1'b0, w_nextY} + K_BALL - 11'd1 >= {1'b0, r_padR});
  assign w_overlapL  = ({1'b0, w_nextY} <= {1'b0, r_padL} + K_PADH - 11'd1) &&
                       ({1'b0, w_nextY} + K_BALL - 11'd1 >= {1'b0, r_padL});
  assign w_missR     = r_dirRight && (w_rightEdge + w_spd11 >= K_HRES);
  assign w_missL     = !r_dirRight && (r_ballX < w_speed);
  assign w_hitR      = r_dirRight && (w_rightEdge < K_RPADX) &&
                       (w_rightEdge + w_spd11 >= K_RPADX) && w_overlapR;
  assign w_hitL      = !r_dirRight && ({1'b0, r_ballX} > K_LPADR) &&
                       ({1'b0, r_ballX} <= K_LPADR + w_spd11) && w_overlapL;
  assign w_nextX     = w_hitR ? RHIT_X :
                       w_hitL ? LHIT_X :
                       r_dirRight ? r_ballX + w_speed : r_ballX - w_speed;

  // Game-control FSM together with all per-frame datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_startQ     <= 1'b0;
      r_startPrev  <= 1'b0;
      r_padL       <= PAD_INIT;
      r_padR       <= PAD_INIT;
      r_ballX      <= BALL_CX;
      r_ballY      <= BALL_CY;
      r_dirRight   <= 1'b1;
      r_dirDown    <= 1'b1;
      r_serveRight <= 1'b1;
      r_scoreL     <= '0;
      r_scoreR     <= '0;
      r_gameOver   <= 1'b0;
      r_pause      <= '0;
`ifdef PONG_SPEEDUP_EN
      r_speed      <= SPEED_V0;
`endif
    end else begin
      r_startQ    <= start;
      r_startPrev <= r_startQ;
      if (w_tick && (r_state == S_SERVE || r_state == S_PLAY)) begin
        r_padL <= padNext(r_padL, btn_l);
        r_padR <= padNext(r_padR, btn_r);
      end
      case (r_state)
        S_IDLE: if (w_startRise) r_state <= S_SERVE;
        S_SERVE: begin
          r_ballX <= BALL_CX;
          r_ballY <= BALL_CY;
`ifdef PONG_SPEEDUP_EN
          r_speed <= SPEED_V0;
`endif
          if (w_startRise) begin
            r_state    <= S_PLAY;
            r_dirRight <= r_serveRight;
            r_dirDown  <= 1'b1;
          end
        end
        S_PLAY: if (w_tick) begin
          if (w_missR || w_missL) begin
            if (w_missR && r_scoreL != K_WIN) r_scoreL <= r_scoreL + SCORE_W'(1);
            if (w_missL && r_scoreR != K_WIN) r_scoreR <= r_scoreR + SCORE_W'(1);
            r_serveRight <= w_missR;
            r_state      <= S_POINT;
            r_pause      <= PAUSE_W'(PAUSE_FRAMES);
            r_ballX      <= BALL_CX;
            r_ballY      <= BALL_CY;
          end else begin
            r_ballX   <= w_nextX;
            r_ballY   <= w_nextY;
            r_dirDown <= w_nextDown;
            if (w_hitR) r_dirRight <= 1'b0;
            else if (w_hitL) r_dirRight <= 1'b1;
`ifdef PONG_SPEEDUP_EN
            if ((w_hitR || w_hitL) && r_speed < 10'(BALL_VMAX)) r_speed <= r_speed + 10'd1;
`endif
          end
        end
        S_POINT: if (w_tick) begin
          if (r_pause <= PAUSE_W'(1)) begin
            if (r_scoreL == K_WIN || r_scoreR == K_WIN) begin
              r_state    <= S_OVER;
              r_gameOver <= 1'b1;
            end else begin
              r_state <= S_SERVE;
            end
          end else begin
            r_pause <= r_pause - PAUSE_W'(1);
          end
        end
        S_OVER: if (w_startRise) begin
          r_scoreL   <= '0;
          r_scoreR   <= '0;
          r_gameOver <= 1'b0;
          r_state    <= S_SERVE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign score_l   = r_scoreL;
  assign score_r   = r_scoreR;
  assign game_over = r_gameOver;

  assign w_px     = {1'b0, pixl_x};
  assign w_py     = {1'b0, pixl_y};
  assign w_onLPad = (w_px >= K_LPADX) && (w_px < K_LPADX + K_PADW) &&
                    (w_py >= {1'b0, r_padL}) && (w_py < {1'b0, r_padL} + K_PADH);
  assign w_onRPad = (w_px >= K_RPADX) && (w_px < K_RPADX + K_PADW) &&
                    (w_py >= {1'b0, r_padR}) && (w_py < {1'b0, r_padR} + K_PADH);
  assign w_onBall = (r_state != S_POINT) &&
                    (w_px >= {1'b0, r_ballX}) && (w_px < {1'b0, r_ballX} + K_BALL) &&
                    (w_py >= {1'b0, r_ballY}) && (w_py < {1'b0, r_ballY} + K_BALL);
  assign w_onLine = (pixl_x == CENTRE_X) && !pixl_y[4];

  always_comb begin
    RGB = 12'h000;
    if (!video_on)     RGB = 12'h000;
    else if (w_onLPad) RGB = 12'h0F0;
    else if (w_onRPad) RGB = 12'h00F;
    else if (w_onBall) RGB = 12'hF00;
    else if (w_onLine) RGB = 12'h888;
  end

endmodule

// File: tb/tb_pong_game_core.sv
// Directed bench for pong_game_core: reset pixel table plus rally, bounce, scoring and win sequences.
module tb_pong_game_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  btn_l, btn_r;
  logic        start, video_on;
  logic [9:0]  pixl_x, pixl_y;
  logic [11:0] RGB;
  logic [3:0]  score_l, score_r;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  pong_game_core dut (
    .clk(clk), .reset(reset), .btn_l(btn_l), .btn_r(btn_r), .start(start),
    .video_on(video_on), .pixl_x(pixl_x), .pixl_y(pixl_y), .RGB(RGB),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vid;
    logic [11:0] rgb;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pixl_x   = v.x;
    pixl_y   = v.y;
    video_on = v.vid;
    #1;
  endtask

  task automatic probe(input int x, input int y, output logic [11:0] c);
    pixl_x   = 10'(x);
    pixl_y   = 10'(y);
    video_on = 1'b1;
    #1;
    c = RGB;
  endtask

  // One frame: park on the tick coordinate across exactly one rising edge.
  task automatic tick();
    @(negedge clk);
    pixl_x = 10'd0;
    pixl_y = 10'd481;
    @(negedge clk);
    pixl_y = 10'd500;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic startPulse();
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Ball top-left must be exactly (x,y): corner pixels red, the pixels just outside not red.
  task automatic checkBall(input string name, input int x, input int y);
    logic [11:0] c0, cd, cl, cu;
    logic [3:0]  ok;
    probe(x, y, c0);
    probe(x + 7, y + 7, cd);
    cl = 12'h000;
    cu = 12'h000;
    if (x > 0) probe(x - 1, y, cl);
    if (y > 0) probe(x, y - 1, cu);
    ok = {c0 == 12'hF00, cd == 12'hF00, cl != 12'hF00, cu != 12'hF00};
    checkOutput(name, 32'(ok), 32'hF);
  endtask

  task automatic checkPixel(input string name, input int x, input int y, input logic [11:0] exp);
    logic [11:0] c;
    probe(x, y, c);
    checkOutput(name, 32'(c), 32'(exp));
  endtask

  task automatic playPoint(input int expR);
    int n;
    n = 0;
    while (32'(score_r) != expR && n < 600) begin
      tick();
      n++;
    end
    checkOutput($sformatf("point_r%0d", expR), 32'(score_r), 32'(expR));
  endtask

  initial begin
    vecs[0]  = '{10'd32,  10'd204, 1'b1, 12'h0F0};
    vecs[1]  = '{10'd35,  10'd275, 1'b1, 12'h0F0};
    vecs[2]  = '{10'd31,  10'd204, 1'b1, 12'h000};
    vecs[3]  = '{10'd32,  10'd203, 1'b1, 12'h000};
    vecs[4]  = '{10'd36,  10'd240, 1'b1, 12'h000};
    vecs[5]  = '{10'd32,  10'd276, 1'b1, 12'h000};
    vecs[6]  = '{10'd600, 10'd204, 1'b1, 12'h00F};
    vecs[7]  = '{10'd603, 10'd275, 1'b1, 12'h00F};
    vecs[8]  = '{10'd316, 10'd236, 1'b1, 12'hF00};
    vecs[9]  = '{10'd323, 10'd243, 1'b1, 12'hF00};
    vecs[10] = '{10'd324, 10'd243, 1'b1, 12'h000};
    vecs[11] = '{10'd315, 10'd236, 1'b1, 12'h000};
    vecs[12] = '{10'd320, 10'd0,   1'b1, 12'h888};
    vecs[13] = '{10'd320, 10'd16,  1'b1, 12'h000};
    vecs[14] = '{10'd320, 10'd40,  1'b1, 12'h888};
    vecs[15] = '{10'd32,  10'd204, 1'b0, 12'h000};
    vecs[16] = '{10'd320, 10'd236, 1'b1, 12'hF00};

    btn_l = 2'b00; btn_r = 2'b00; start = 1'b0; video_on = 1'b0;
    pixl_x = 10'd100; pixl_y = 10'd100;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("reset_pix[%0d]", i), 32'(RGB), 32'(vecs[i].rgb));
    end
    checkOutput("reset_scores", {24'd0, score_l, score_r}, 32'd0);
    checkOutput("reset_game_over", 32'(game_over), 32'd0);

    // Paddle clamp at the bottom, then both buttons freeze it
    startPulse();
    btn_l = 2'b10;
    ticks(100);
    checkPixel("lpad_bottom_top", 32, 408, 12'h0F0);
    checkPixel("lpad_bottom_above", 32, 407, 12'h000);
    checkPixel("lpad_bottom_end", 32, 479, 12'h0F0);
    btn_l = 2'b11;
    ticks(5);
    checkPixel("lpad_both_btn", 32, 408, 12'h0F0);
    checkPixel("lpad_both_btn_above", 32, 407, 12'h000);
    btn_l = 2'b00;
    btn_r = 2'b10;
    ticks(60);
    btn_r = 2'b00;
    checkPixel("rpad_bottom", 600, 408, 12'h00F);

    // Rally: bottom bounce, right paddle hit, top bounce, left miss
    startPulse();
    ticks(236);
    checkBall("ball_at_floor", 552, 472);
    tick();
    checkBall("floor_bounce", 553, 472);
    tick();
    checkBall("after_floor", 554, 471);
    ticks(37);
    checkBall("before_rhit", 591, 434);
    tick();
    checkBall("rhit_clamp", 592, 433);
    tick();
    checkBall("after_rhit", 591, 432);
    ticks(432);
    checkBall("ball_at_top", 159, 0);
    tick();
    checkBall("top_bounce", 158, 0);
    tick();
    checkBall("after_top", 157, 1);
    ticks(157);
    checkBall("ball_at_left", 0, 158);
    tick();
    checkOutput("miss_score_r", 32'(score_r), 32'd1);
    checkOutput("miss_score_l", 32'(score_l), 32'd0);
    ticks(59);
    checkPixel("ball_hidden", 316, 236, 12'h000);
    tick();
    checkBall("serve_centre", 316, 236);

    // Left player lost, so the serve heads left; left paddle parks at the top
    btn_l = 2'b01;
    startPulse();
    tick();
    checkBall("serve_left", 315, 237);
    playPoint(2);
    ticks(60);
    for (int p = 3; p <= 9; p++) begin
      startPulse();
      playPoint(p);
      ticks(60);
    end
    checkOutput("over_flag", 32'(game_over), 32'd1);
    checkOutput("over_score_l", 32'(score_l), 32'd0);

    btn_l = 2'b10;
    ticks(5);
    checkPixel("over_frozen_top", 32, 0, 12'h0F0);
    checkPixel("over_frozen_below", 32, 72, 12'h000);

    // Restart: state change lands on the second edge after start rises
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checkOutput("restart_1clk", 32'(game_over), 32'd1);
    @(negedge clk);
    checkOutput("restart_2clk", 32'(game_over), 32'd0);
    checkOutput("restart_scores", {24'd0, score_l, score_r}, 32'd0);
    start = 1'b0;
    tick();
    checkPixel("serve_pad_move", 32, 4, 12'h0F0);
    checkPixel("serve_pad_move_above", 32, 3, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
